// File: rtl/mem_access_unit.sv
// Memory-stage load/store sequencer: Dcache req/ack handshake,
// load alignment/extension, stall, misalign and timeout flags.
module mem_access_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EXMem_LdEN,
  input  logic                  EXMem_StEN,
  input  logic [2:0]            EXMem_LdType,
  input  logic [1:0]            EXMem_StType,
  input  logic [DATA_WIDTH-1:0] EXMem_AluData,
  input  logic [DATA_WIDTH-1:0] EXMem_Rs2Data,
  input  logic [4:0]            EXMem_RdAddr,
  output logic                  Dcache_Req,
  output logic                  Dcache_Wr,
  output logic [DATA_WIDTH-1:0] Dcache_Addr,
  output logic [DATA_WIDTH-1:0] Dcache_WrData,
  output logic [3:0]            Dcache_ByteEn,
  input  logic                  Dcache_Ack,
  input  logic [DATA_WIDTH-1:0] Dcache_RdRaw,
  output logic                  Mem_LdEN,
  output logic [DATA_WIDTH-1:0] Mem_LdData,
  output logic [4:0]            Mem_RdAddr,
  output logic                  Mem_Stall,
  output logic                  Mem_Misalign,
  output logic                  Mem_BusErr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            ldtype_q;
  logic [1:0]            off_q;
  logic [4:0]            rd_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [DATA_WIDTH-1:0] ldata_q;
  logic [4:0]            rdout_q;
  logic                  buserr_q;

  logic                  access;
  logic                  ld_byte, ld_half;
  logic                  st_byte, st_half;
  logic                  misal;
  logic                  start;
  logic                  timeout;
  logic [3:0]            be_d;
  logic [DATA_WIDTH-1:0] wd_d;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ext;

  // Decode of the access sitting in EX/Mem
  always_comb begin
    access  = EXMem_LdEN | EXMem_StEN;
    ld_byte = (EXMem_LdType == 3'b000) || (EXMem_LdType == 3'b100);
    ld_half = (EXMem_LdType == 3'b001) || (EXMem_LdType == 3'b101);
    st_byte = (EXMem_StType == 2'b00);
    st_half = (EXMem_StType == 2'b01);
    misal   = 1'b0;
    be_d    = 4'b1111;
    wd_d    = EXMem_Rs2Data;
    if (EXMem_LdEN) begin
      if (ld_half)       misal = EXMem_AluData[0];
      else if (!ld_byte) misal = |EXMem_AluData[1:0];
    end else begin
      if (st_half)       misal = EXMem_AluData[0];
      else if (!st_byte) misal = |EXMem_AluData[1:0];
    end
    unique case (1'b1)
      st_byte: begin
        be_d = 4'b0001 << EXMem_AluData[1:0];
        wd_d = {4{EXMem_Rs2Data[7:0]}};
      end
      st_half: begin
        be_d = 4'b0011 << {EXMem_AluData[1], 1'b0};
        wd_d = {2{EXMem_Rs2Data[15:0]}};
      end
      default: begin
        be_d = 4'b1111;
        wd_d = EXMem_Rs2Data;
      end
    endcase
  end

  assign start   = (state_q == IDLE) && access && !misal;
  assign timeout = (cnt_q == CNT_WIDTH'(ACK_TIMEOUT - 1));

  // Load extraction from the raw word, using the latched offset
  always_comb begin
    shifted = Dcache_RdRaw >> {off_q, 3'b000};
    unique case (ldtype_q)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ext = {24'b0, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ext = {16'b0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = REQ;
      REQ: begin
        if (Dcache_Ack)   state_d = RESP;
        else if (timeout) state_d = IDLE;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      be_q     <= 4'b0;
      wdata_q  <= '0;
      ldtype_q <= 3'b0;
      off_q    <= 2'b0;
      rd_q     <= 5'b0;
      cnt_q    <= '0;
      ldata_q  <= '0;
      rdout_q  <= 5'b0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buserr_q <= (state_q == REQ) && !Dcache_Ack && timeout;
      if (start) begin
        addr_q   <= {EXMem_AluData[DATA_WIDTH-1:2], 2'b00};
        wr_q     <= !EXMem_LdEN;
        be_q     <= EXMem_LdEN ? 4'b0 : be_d;
        wdata_q  <= EXMem_LdEN ? '0 : wd_d;
        ldtype_q <= EXMem_LdType;
        off_q    <= EXMem_AluData[1:0];
        rd_q     <= EXMem_RdAddr;
        cnt_q    <= '0;
      end else if (state_q == REQ) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if ((state_q == REQ) && Dcache_Ack && !wr_q) begin
        ldata_q <= ext;
        rdout_q <= rd_q;
      end
    end
  end

  assign Dcache_Req    = (state_q == REQ);
  assign Dcache_Wr     = wr_q;
  assign Dcache_Addr   = addr_q;
  assign Dcache_WrData = wdata_q;
  assign Dcache_ByteEn = be_q;
  assign Mem_LdEN      = (state_q == RESP) && !wr_q;
  assign Mem_LdData    = ldata_q;
  assign Mem_RdAddr    = rdout_q;
  assign Mem_Stall     = start || (state_q == REQ);
  assign Mem_Misalign  = (state_q == IDLE) && access && misal;
  assign Mem_BusErr    = buserr_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store sequencer. Takes the access held in the EX/Mem register and runs a request/acknowledge transaction with the data cache.
- For loads, it aligns and extends the returned word, then presents it with a one-cycle Mem_LdEN strobe. This is the producer of the Dcache load data and Mem_LdEN that EX-stage forwarding consumes.
- Stalls the pipeline while a transaction is outstanding. Flags misaligned accesses and cache timeouts.

Parameters:
- DATA_WIDTH, 32, data/address width; only 32 is supported.
- ACK_TIMEOUT, 16, maximum number of cycles Dcache_Req may wait for Dcache_Ack before a bus error is raised; must be ≥2.
- CNT_WIDTH, 5, width of the timeout counter; must hold ACK_TIMEOUT.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- EXMem_LdEN  in  1  instruction in Mem is a load
- EXMem_StEN  in  1  instruction in Mem is a store
- EXMem_LdType  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- EXMem_StType  in  2  00 SB, 01 SH, 10 SW
- EXMem_AluData  in  32  effective address
- EXMem_Rs2Data  in  32  store data
- EXMem_RdAddr  in  5  load destination register
- Dcache_Req  out  1  request valid
- Dcache_Wr  out  1  1 = write, 0 = read
- Dcache_Addr  out  32  word address: {addr[31:2], 2'b00}
- Dcache_WrData  out  32  lane-replicated store data
- Dcache_ByteEn  out  4  store byte enables; 4'b0000 on reads
- Dcache_Ack  in  1  request accepted/completed; read data valid in the same cycle
- Dcache_RdRaw  in  32  raw read word
- Mem_LdEN  out  1  one-cycle strobe: Mem_LdData/Mem_RdAddr valid
- Mem_LdData  out  32  aligned, extended load result
- Mem_RdAddr  out  5  destination register of the completed load
- Mem_Stall  out  1  hold IF..Mem pipeline registers
- Mem_Misalign  out  1  one-cycle misaligned-access flag
- Mem_BusErr  out  1  one-cycle timeout flag

Behaviour:
- FSM states: IDLE, REQ, RESP. All outputs reset to 0 and the state resets to IDLE asynchronously; reset mid-transaction drops Dcache_Req immediately and discards the access.
- IDLE: access = EXMem_LdEN | EXMem_StEN. If LdEN and StEN are both high, treat it as a load.
- Misalignment rules: LH/LHU with addr[0]=1; LW with addr[1:0]≠0; SH with addr[0]=1; SW with addr[1:0]≠0.
- Misaligned access in IDLE: Mem_Misalign=1 combinationally for that cycle, no request issued, no stall, stay IDLE.
- Aligned access in IDLE: Mem_Stall=1 combinationally, then go to REQ. Latch addr, Wr, ByteEn, WrData, LdType, addr[1:0], RdAddr; clear the counter.
- REQ: Dcache_Req=1 with registered address/controls held stable until Ack. Mem_Stall=1.
  - On Dcache_Ack: capture Dcache_RdRaw and go to RESP.
  - Otherwise, when the counter reaches ACK_TIMEOUT-1 without Ack: Mem_BusErr=1 for one cycle (registered) and go to IDLE with no LdEN.
  - An Ack arriving in the same cycle as the timeout wins; no error.
- RESP (one cycle): Mem_Stall=0 so the pipeline advances at the end of this cycle. For loads, Mem_LdEN=1 with Mem_LdData and Mem_RdAddr valid; stores produce no strobe. Next state is IDLE.
- Load latency: access in cycle 0 → Req from cycle 1 → Ack in cycle k → Mem_LdEN in cycle k+1. Minimum latency is 2 cycles.
- Mem_LdData and Mem_RdAddr hold their last values when Mem_LdEN=0.
- Load extraction: sh = addr[1:0]*8; raw = Dcache_RdRaw >> sh.
  - LB: sign-extend raw[7:0].
  - LBU: zero-extend raw[7:0].
  - LH: sign-extend raw[15:0].
  - LHU: zero-extend raw[15:0].
  - LW: raw.
  - Other LdType codes: treat as LW.
- Store lanes:
  - SB: ByteEn = 4'b0001<<addr[1:0]; WrData = {4{rs2[7:0]}}.
  - SH: ByteEn = 4'b0011<<{addr[1],1'b0}; WrData = {2{rs2[15:0]}}.
  - SW: ByteEn = 4'b1111; WrData = rs2.
  - StType 11: treat as SW.
- Back-to-back accesses: the new access is sampled in the IDLE cycle after RESP; there are no idle cycles beyond that.

Test Plan:
- LW at 0x100, Ack in cycle 1 (Req's first cycle), RdRaw=0xDEADBEEF → Mem_LdEN in cycle 2, data 0xDEADBEEF; Stall high in cycles 0–1 only.
- LB at 0x103, RdRaw=0x80112233 → 0xFFFFFF80; LBU same → 0x00000080; LHU at 0x102, RdRaw=0x8001_0000 → 0x00008001.
- SH at 0x206, rs2=0x1234ABCD → Addr=0x204, ByteEn=4'b1100, WrData=0xABCDABCD, Wr=1; no Mem_LdEN.
- LW at 0x101 → Mem_Misalign=1 for one cycle; Dcache_Req never asserts; Stall stays 0.
- Ack withheld for 16 cycles → Mem_BusErr pulse; FSM returns to IDLE; no LdEN. Repeat with Ack on the last cycle → normal completion, no error.
- rst_n low while in REQ → Req and Stall drop immediately; after release, the next load completes normally.
